m_axis_rc_drop_fifo_x4: RTL and testbench
=========================================

# m_axis_rc_drop_fifo_x4

Store-and-forward completion packet FIFO directly downstream of the x4 128-bit RC adapter, feeding the LitePCIe completion depacketizer. Buffers whole legacy-format completion TLPs and releases a packet only after its last beat is accepted. Packets flagged discontinue (tuser[0]) on any beat are rolled back and never appear on the output.

## Interface
- DATA_WIDTH, 128, beat data width
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width
- DEPTH, 64, beats of storage; power of two, ≥ 16
- user_clk  in  1  sole clock
- user_reset  in  1  reset; synchronous, active-high
- s_axis_rc_tdata / tkeep / tlast / tuser / tvalid  in  128/16/1/85/1  adapter output stream
- s_axis_rc_tready  out  4  all four bits identical, drive adapter tready
- m_axis_rc_tdata / tkeep / tlast / tuser / tvalid  out  128/16/1/85/1  filtered stream
- m_axis_rc_tready  in  1  downstream ready
- drop_pulse  out  1  one-cycle pulse per dropped packet
- drop_count  out  16  saturating count of dropped packets
- overflow  out  1  sticky; packet exceeded DEPTH

## Operation
- Storage: DEPTH × (tdata, tkeep, tlast, full tuser); write pointer wr_ptr, committed pointer wr_cmt, read pointer rd_ptr; all ADDR_W+1 bits (ADDR_W = log2 DEPTH), extra bit for wrap.
- Input accepted on s tvalid && s tready; beat written at wr_ptr, wr_ptr += 1.
- Sticky bad flag: set on any accepted beat with tuser[0]=1; includes the tlast beat itself.
- On accepted tlast: bad (incl. current beat) → wr_ptr ← wr_cmt, drop_pulse=1, drop_count += 1 (saturate at 16'hFFFF); else wr_cmt ← wr_ptr+1. Bad flag cleared.
- s tready = (wr_ptr − rd_ptr) ≠ DEPTH, OR discard mode active.
- Oversize: buffer full and wr_cmt == rd_ptr (nothing committed to drain) → enter discard mode: wr_ptr ← wr_cmt, overflow ← 1, accept and discard all beats through tlast, then drop_pulse/drop_count as for a bad packet; discard mode clears after tlast.
- Read side only sees entries in [rd_ptr, wr_cmt). Output register stage: one registered beat plus memory read, first-word-fall-through.
- tuser, tkeep, tdata passed unmodified for surviving packets.

## Timing
- Reset values: m tvalid 0, m tdata/tkeep/tuser/tlast 0, drop_pulse 0, drop_count 0, overflow 0, all pointers 0, bad flag 0, discard mode 0; s tready 1 from first cycle after reset.
- Latency: tlast of a good packet accepted in cycle N → first beat m tvalid in cycle N+2 (empty FIFO, m tready high).
- Throughput: one beat/cycle in and out sustained.
- m tvalid, once high, holds with stable data until m tready.
- Commit and read in the same cycle both take effect; rollback and read in the same cycle both take effect (rd_ptr never passes wr_cmt).
- drop_pulse asserts the cycle after the offending tlast is accepted.
- Reset mid-packet: partial packet lost, output packet in flight truncated; no drop counted.

## Configuration
- RC_DROP_POISONED_EN defined: tuser[1] (poisoned/err_fwd) also sets the bad flag; poisoned completions dropped and counted.
- Undefined: tuser[1] ignored for filtering; poisoned completions forwarded with tuser[1] intact.

## Test plan
- Three good 4-beat packets back-to-back, m tready=1 → identical 12 beats out, first beat 2 cycles after first tlast, drop_count=0.
- 4-beat packet with tuser[0]=1 on beat 2, followed by good 2-beat packet → only the 2-beat packet emerges; drop_pulse once; drop_count=1.
- tuser[0]=1 only on tlast beat of single-beat packet → nothing out; drop_count=1.
- DEPTH=16, m tready=0, send 20-beat packet → overflow=1, s tready stays high, packet dropped; next good packet passes after tready restored.
- m tready toggling 50% while filling to full with 8-beat packets → no beat lost or duplicated; s tready low exactly when 16 beats held.
- Poisoned packet (tuser[1]=1): with RC_DROP_POISONED_EN dropped, drop_count=1; without it forwarded unchanged.

Source files
------------

// File: rtl/m_axis_rc_drop_fifo_x4.sv
// Store-and-forward RC completion FIFO that rolls back discontinued packets.
// Optional RC_DROP_POISONED_EN also drops poisoned (tuser[1]) completions.
module m_axis_rc_drop_fifo_x4 #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int DEPTH      = 64
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rc_tkeep,
  input  logic                  s_axis_rc_tlast,
  input  logic [84:0]           s_axis_rc_tuser,
  input  logic                  s_axis_rc_tvalid,
  output logic [3:0]            s_axis_rc_tready,
  output logic [DATA_WIDTH-1:0] m_axis_rc_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep,
  output logic                  m_axis_rc_tlast,
  output logic [84:0]           m_axis_rc_tuser,
  output logic                  m_axis_rc_tvalid,
  input  logic                  m_axis_rc_tready,
  output logic                  drop_pulse,
  output logic [15:0]           drop_count,
  output logic                  overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int UW     = 85;
  localparam int W      = DATA_WIDTH + KEEP_WIDTH + 1 + UW;

  typedef logic [ADDR_W:0] ptr_t;

  logic [W-1:0] mem_q [DEPTH];

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        wr_cmt_q, wr_cmt_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic        bad_q, bad_d;
  logic        disc_q, disc_d;
  logic        ovf_q, ovf_d;
  logic        drop_q, drop_d;
  logic [15:0] cnt_q, cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [W-1:0] m_word_q, m_word_d;

  logic full, enter_disc, discard, s_rdy, s_acc;
  logic beat_bad, wr_en, load;

  always_comb begin
    full       = (wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);
    // A full buffer with nothing committed can never drain: give up on it.
    enter_disc = full && (wr_cmt_q == rd_ptr_q) && !disc_q;
    discard    = disc_q || enter_disc;
    s_rdy      = !full || discard;
    s_acc      = s_axis_rc_tvalid && s_rdy;
`ifdef RC_DROP_POISONED_EN
    beat_bad   = s_axis_rc_tuser[0] | s_axis_rc_tuser[1];
`else
    beat_bad   = s_axis_rc_tuser[0];
`endif
    wr_en      = s_acc && !discard;

    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    bad_d    = bad_q;
    disc_d   = disc_q;
    ovf_d    = ovf_q;
    drop_d   = 1'b0;
    cnt_d    = cnt_q;

    if (enter_disc) begin
      wr_ptr_d = wr_cmt_q;
      ovf_d    = 1'b1;
      disc_d   = 1'b1;
    end

    if (s_acc) begin
      if (discard) begin
        if (s_axis_rc_tlast) begin
          disc_d = 1'b0;
          bad_d  = 1'b0;
          drop_d = 1'b1;
        end
      end else if (s_axis_rc_tlast) begin
        bad_d = 1'b0;
        if (bad_q || beat_bad) begin
          wr_ptr_d = wr_cmt_q;
          drop_d   = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          wr_cmt_d = wr_ptr_q + 1'b1;
        end
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        bad_d    = bad_q | beat_bad;
      end
    end

    if (drop_d && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    m_word_d  = m_word_q;
    load      = (rd_ptr_q != wr_cmt_q) && (!m_valid_q || m_axis_rc_tready);
    if (load) begin
      m_word_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end else if (m_axis_rc_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (wr_en)
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_rc_tdata, s_axis_rc_tkeep,
                                      s_axis_rc_tlast, s_axis_rc_tuser};
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wr_ptr_q  <= '0;
      wr_cmt_q  <= '0;
      rd_ptr_q  <= '0;
      bad_q     <= 1'b0;
      disc_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_word_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_cmt_q  <= wr_cmt_d;
      rd_ptr_q  <= rd_ptr_d;
      bad_q     <= bad_d;
      disc_q    <= disc_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_word_q  <= m_word_d;
    end
  end

  assign s_axis_rc_tready = {4{s_rdy}};
  assign m_axis_rc_tvalid = m_valid_q;
  assign m_axis_rc_tuser  = m_word_q[UW-1:0];
  assign m_axis_rc_tlast  = m_word_q[UW];
  assign m_axis_rc_tkeep  = m_word_q[UW+1 +: KEEP_WIDTH];
  assign m_axis_rc_tdata  = m_word_q[UW+1+KEEP_WIDTH +: DATA_WIDTH];
  assign drop_pulse       = drop_q;
  assign drop_count       = cnt_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_m_axis_rc_drop_fifo_x4.sv
// Directed bench for m_axis_rc_drop_fifo_x4 (DEPTH=16).
// Packet table plus hand-written overflow and back-pressure sequences.
module tb_m_axis_rc_drop_fifo_x4;

  localparam int DW    = 128;
  localparam int KW    = 16;
  localparam int UW    = 85;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic [KW-1:0] s_keep = '0;
  logic          s_last = 1'b0;
  logic [UW-1:0] s_user = '0;
  logic          s_valid = 1'b0;
  logic [3:0]    s_tready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic          m_last;
  logic [UW-1:0] m_user;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          drop_pulse;
  logic [15:0]   drop_count;
  logic          overflow;

  always #5 clk = ~clk;

  m_axis_rc_drop_fifo_x4 #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH)) dut (
    .user_clk(clk), .user_reset(rst),
    .s_axis_rc_tdata(s_data), .s_axis_rc_tkeep(s_keep),
    .s_axis_rc_tlast(s_last), .s_axis_rc_tuser(s_user),
    .s_axis_rc_tvalid(s_valid), .s_axis_rc_tready(s_tready),
    .m_axis_rc_tdata(m_data), .m_axis_rc_tkeep(m_keep),
    .m_axis_rc_tlast(m_last), .m_axis_rc_tuser(m_user),
    .m_axis_rc_tvalid(m_valid), .m_axis_rc_tready(m_ready),
    .drop_pulse(drop_pulse), .drop_count(drop_count), .overflow(overflow)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  typedef struct {
    int len;
    int bad_at;
    bit poi;
    bit pass;
    bit chk;
    int drops;
  } vec_t;

  beat_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int drops_seen = 0;
  int first_mv = -1;
  int in_cnt = 0;
  int out_cnt = 0;
  int low_seen = 0;
  bit chk_full = 1'b0;

  always @(posedge clk) cyc++;

  function automatic beat_t mk(int id, int b, int len, bit bad, bit poi);
    beat_t x;
    x.d = {32'(id), 32'(b), 64'h0123_4567_89AB_CDEF ^ 64'(id * 7 + b)};
    x.k = (b == len - 1) ? 16'h0FFF : 16'hFFFF;
    x.l = (b == len - 1);
    x.u = {77'(id * 256 + b), 6'b0, poi, bad};
    return x;
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (drop_pulse === 1'b1) drops_seen++;
    if (m_valid === 1'b1 && first_mv < 0) first_mv = cyc;
    if (chk_full) begin
      n_vec++;
      if (s_tready[0] != ((in_cnt - out_cnt - int'(m_valid)) != DEPTH)) begin
        n_err++;
        $display("FAIL full_flag: tready=%0b held=%0d", s_tready[0],
                 in_cnt - out_cnt - int'(m_valid));
      end
      if (!s_tready[0]) low_seen++;
    end
    if (m_valid === 1'b1 && m_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: got data %h user %h, required none",
                 m_data, m_user);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e.d || m_keep !== e.k || m_last !== e.l || m_user !== e.u) begin
          n_err++;
          $display("FAIL out_beat: got %h/%h/%b/%h required %h/%h/%b/%h",
                   m_data, m_keep, m_last, m_user, e.d, e.k, e.l, e.u);
        end
      end
      out_cnt++;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    drops_seen = 0;
    first_mv = -1;
    in_cnt = 0;
    out_cnt = 0;
  endtask

  task automatic send_beat(input beat_t b, output int acc_cyc, output bit stalled);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    stalled = 1'b0;
    acc_cyc = 0;
    s_valid = 1'b1;
    s_data = b.d;
    s_keep = b.k;
    s_last = b.l;
    s_user = b.u;
    do begin
      @(negedge clk);
      ok = s_tready[0];
      acc_cyc = cyc;
      if (!ok) stalled = 1'b1;
      @(posedge clk);
      n++;
    end while (!ok && n < 500);
    if (ok) in_cnt++;
    else begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: tready stuck at %0b, required 1", s_tready[0]);
    end
    #1;
  endtask

  task automatic send_pkt(int id, int len, int bad_at, bit poi, bit push,
                          output int last_cyc, output int stalls);
    beat_t x;
    bit st;
    stalls = 0;
    last_cyc = 0;
    for (int b = 0; b < len; b++) begin
      x = mk(id, b, len, b == bad_at, poi);
      send_beat(x, last_cyc, st);
      if (push) exp_q.push_back(x);
      stalls += int'(st);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic drain(int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  vec_t tbl[8];
  int   pdrop;
  int   t0, lc, st;
  bit   done;

  initial begin
`ifdef RC_DROP_POISONED_EN
    pdrop = 3;
    tbl[6] = '{2, -1, 1'b1, 1'b0, 1'b1, 3};
`else
    pdrop = 2;
    tbl[6] = '{2, -1, 1'b1, 1'b1, 1'b1, 2};
`endif
    tbl[0] = '{4, -1, 1'b0, 1'b1, 1'b0, 0};
    tbl[1] = '{4, -1, 1'b0, 1'b1, 1'b0, 0};
    tbl[2] = '{4, -1, 1'b0, 1'b1, 1'b1, 0};
    tbl[3] = '{4,  1, 1'b0, 1'b0, 1'b0, 1};
    tbl[4] = '{2, -1, 1'b0, 1'b1, 1'b1, 1};
    tbl[5] = '{1,  0, 1'b0, 1'b0, 1'b1, 2};
    tbl[7] = '{3, -1, 1'b0, 1'b1, 1'b1, pdrop};

    do_reset();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_tdata_zero", 64'(m_data == '0), 64'd1);
    chk("rst_m_tuser_zero", 64'(m_user == '0), 64'd1);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'hF);

    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      send_pkt(i, tbl[i].len, tbl[i].bad_at, tbl[i].poi, tbl[i].pass, lc, st);
      if (i == 0) t0 = lc;
      if (tbl[i].chk) begin
        drain(200);
        chk("tbl_drop_count", 64'(drop_count), 64'(tbl[i].drops));
        chk("tbl_drop_pulses", 64'(drops_seen), 64'(tbl[i].drops));
        chk("tbl_overflow", 64'(overflow), 64'd0);
      end
    end
    chk("first_beat_latency", 64'(first_mv - t0), 64'd2);
    chk("tbl_out_beats", 64'(out_cnt), 64'd4 * 3 + 2 + 3 + (pdrop == 2 ? 2 : 0));

    // Oversize packet with output blocked.
    do_reset();
    m_ready = 1'b0;
    send_pkt(20, 20, -1, 1'b0, 1'b0, lc, st);
    chk("ovf_no_stall", 64'(st), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_count", 64'(drop_count), 64'd1);
    chk("ovf_drop_pulses", 64'(drops_seen), 64'd1);
    chk("ovf_no_output", 64'(m_valid), 64'd0);
    m_ready = 1'b1;
    send_pkt(21, 3, -1, 1'b0, 1'b1, lc, st);
    drain(100);
    chk("ovf_next_out", 64'(out_cnt), 64'd3);
    chk("ovf_flag_sticky", 64'(overflow), 64'd1);

    // Alternating back-pressure while filling with 8-beat packets.
    do_reset();
    low_seen = 0;
    done = 1'b0;
    chk_full = 1'b1;
    fork
      begin
        int lc2, st2;
        for (int p = 0; p < 6; p++)
          send_pkt(30 + p, 8, -1, 1'b0, 1'b1, lc2, st2);
        done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!done && n < 2000) begin
          @(posedge clk);
          #1 m_ready = ~m_ready;
          n++;
        end
      end
    join
    @(posedge clk);
    #1;
    chk_full = 1'b0;
    m_ready = 1'b1;
    drain(300);
    chk("bp_out_beats", 64'(out_cnt), 64'd48);
    chk("bp_full_reached", 64'(low_seen > 0), 64'd1);
    chk("bp_drop_count", 64'(drop_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
